fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } arb_state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int STATS_CNT_W    = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: combinational, zero latency; picks the first requester at or after ptr.
// No backpressure of its own; the caller decides whether the pick becomes a grant.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx
);

   logic             found;
   int               pos;
   logic [IDX_W-1:0] cand;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      pos      = 0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Rotate the search origin to ptr, wrapping past NUM_REQ-1.
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         cand = IDX_W'(pos);
         if (!found && req[cand]) begin
            found      = 1'b1;
            pick[cand] = 1'b1;
            pick_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding fifo_memory: grant is combinational, write strobe/data one cycle later.
// Grants are withheld once occupancy plus any in-flight write reaches DEPTH; FIFO_WR_ARBITER_STATS_EN adds grant_cnt.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_REQ    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   input  logic                          fifo_read_enable,
   input  logic                          fifo_full,
   output logic                          fifo_write_enable,
   output logic [DATA_WIDTH-1:0]         fifo_write_data,
   output logic [ADDR_WIDTH:0]           occupancy,
   output logic                          err
`ifdef FIFO_WR_ARBITER_STATS_EN
   ,
   output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [ADDR_WIDTH+1:0] FILL_LIMIT = (ADDR_WIDTH+2)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   OCC_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   OCC_DM1    = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   OCC_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);

   arb_state_t                state_q, state_d;
   logic [IDX_W-1:0]          ptr_q;
   logic [ADDR_WIDTH:0]       occ_q, occ_d;
   logic                      we_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic                      err_q;

   logic [ADDR_WIDTH+1:0]     fill;
   logic                      credit;
   logic [NUM_REQ-1:0]        pick;
   logic [IDX_W-1:0]          pick_idx;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic                      rd_ok;
   logic                      err_set;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   // The in-flight write is counted so a grant at DEPTH-1 cannot overfill.
   assign fill   = {1'b0, occ_q} + {{(ADDR_WIDTH+1){1'b0}}, we_q};
   assign credit = (fill < FILL_LIMIT);

   always_comb begin
      state_d = state_q;
      grant   = '0;
      if (!credit) begin
         state_d = STALL;
      end else if (|req) begin
         state_d = RUN;
      end else begin
         state_d = IDLE;
      end
      if (!rst && (state_q == RUN) && credit) begin
         grant = pick;
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign rd_ok = fifo_read_enable && (occ_q != '0);

   always_comb begin
      occ_d = occ_q;
      case ({we_q, rd_ok})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase
   end

   // The full flag may lag the credit count by one word, so only gross disagreement is flagged.
   assign err_set = (fifo_read_enable && (occ_q == '0))
                  || (fifo_full && (occ_q < OCC_DM1))
                  || (!fifo_full && (occ_q == OCC_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         occ_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         we_q    <= |grant;
         err_q   <= err_q | err_set;
         if (|grant) begin
            wdata_q <= sel_data;
            ptr_q   <= (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_ONE;
         end
      end
   end

   assign fifo_write_enable = we_q;
   assign fifo_write_data   = wdata_q;
   assign occupancy         = occ_q;
   assign err               = err_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
   logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + STATS_CNT_W'(1);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[g*STATS_CNT_W +: STATS_CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DEPTH=4) with a queue scoreboard and negedge monitor.
module tb_fifo_wr_arbiter;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int NR    = 4;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req = '0;
   logic [NR*DW-1:0]  req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
   logic [NR-1:0]     grant;
   logic              fifo_read_enable = 1'b0;
   logic              fifo_full = 1'b0;
   logic              fifo_write_enable;
   logic [DW-1:0]     fifo_write_data;
   logic [AW:0]       occupancy;
   logic              err;
`ifdef FIFO_WR_ARBITER_STATS_EN
   logic [NR*16-1:0]  grant_cnt;
`endif

   int tests    = 0;
   int fails    = 0;
   int n_grants = 0;
   int mem_cnt  = 0;
   bit auto_rd  = 1'b0;
   int exp_g[$];
   logic [DW-1:0] exp_d[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REQ    (NR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req),
      .req_data          (req_data),
      .grant             (grant),
      .fifo_read_enable  (fifo_read_enable),
      .fifo_full         (fifo_full),
      .fifo_write_enable (fifo_write_enable),
      .fifo_write_data   (fifo_write_data),
      .occupancy         (occupancy),
      .err               (err)
`ifdef FIFO_WR_ARBITER_STATS_EN
      ,
      .grant_cnt         (grant_cnt)
`endif
   );

   // Stand-in for fifo_memory: counts words so the full flag is realistic.
   always @(posedge clk) begin
      if (rst) mem_cnt <= 0;
      else mem_cnt <= mem_cnt + (fifo_write_enable ? 1 : 0)
                              - ((fifo_read_enable && mem_cnt > 0) ? 1 : 0);
   end

   initial forever begin
      @(posedge clk);
      #1;
      fifo_full = (mem_cnt == DEPTH);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (auto_rd) fifo_read_enable = (mem_cnt != 0);
   endtask

   task automatic push(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         exp_g.push_back(idx);
         exp_d.push_back(req_data[idx*DW +: DW]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      auto_rd = 1'b0;
      fifo_read_enable = 1'b0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_occupancy", int'(occupancy), 0);
      check("rst_write_enable", int'(fifo_write_enable), 0);
      check("rst_write_data", int'(fifo_write_data), 0);
      check("rst_err", int'(err), 0);
   endtask

   // Hold pattern r until n grants have been seen, then release; cyc counts cycles used.
   task automatic run_req(input logic [NR-1:0] r, input int n, output int cyc);
      int got;
      got = 0;
      cyc = 0;
      step();
      req = r;
      while (got < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (grant != '0) got++;
         if (got < n) step();
      end
      check("run_req_grants", got, n);
      step();
      req = '0;
   endtask

   // Monitor: every grant and every write is checked against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (grant != '0) begin
         int gi;
         gi = -1;
         for (int i = 0; i < NR; i++) if (grant[i]) gi = i;
         check("grant_onehot", $countones(grant), 1);
         check("grant_has_req", int'(req[gi]), 1);
         if (exp_g.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL grant_unexpected: got requester %0d, expected none", gi);
         end else begin
            check("grant_idx", gi, exp_g.pop_front());
         end
         n_grants++;
      end
      if (fifo_write_enable) begin
         if (exp_d.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL write_unexpected: got data %0h, expected none", fifo_write_data);
         end else begin
            check("write_data", int'(fifo_write_data), int'(exp_d.pop_front()));
         end
      end
   end

   initial begin
      int cyc;
      int base;

      // Round-robin order 0,1,2,3,0 with a draining consumer, back-to-back.
      do_reset();
      auto_rd = 1'b1;
      push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
      run_req(4'b1111, 5, cyc);
      check("b2b_cycles", cyc, 6);
      // Sparse pattern continues from pointer 1.
      push(1, 1); push(3, 1); push(1, 1);
      run_req(4'b1010, 3, cyc);
      repeat (4) step();
      auto_rd = 1'b0;
      fifo_read_enable = 1'b0;
      repeat (2) step();
      check("drain_err", int'(err), 0);

      // Credit limit with DEPTH=4, then single-read refills and a coincident write/read.
      do_reset();
      base = n_grants;
      push(1, 6);
      step();
      req = 4'b0010;
      repeat (10) step();
      @(negedge clk);
      check("stall_grants", n_grants - base, 4);
      check("stall_occupancy", int'(occupancy), 4);
      step(); fifo_read_enable = 1'b1;
      step(); fifo_read_enable = 1'b0;
      step();
      step(); fifo_read_enable = 1'b1;
      step(); fifo_read_enable = 1'b0;
      @(negedge clk);
      check("wr_rd_same_cycle_occ", int'(occupancy), 3);
      check("refill_grants", n_grants - base, 5);
      repeat (6) step();
      @(negedge clk);
      check("refill2_grants", n_grants - base, 6);
      check("refill2_occupancy", int'(occupancy), 4);
      check("credit_err", int'(err), 0);
      step();
      req = '0;

      // Read at empty: ignored for counting, sticky err.
      do_reset();
      step(); fifo_read_enable = 1'b1;
      step(); fifo_read_enable = 1'b0;
      @(negedge clk);
      check("empty_rd_occupancy", int'(occupancy), 0);
      check("empty_rd_err", int'(err), 1);
      repeat (5) step();
      @(negedge clk);
      check("err_sticky", int'(err), 1);

      // Reset the cycle after a grant discards the in-flight write and the pointer.
      do_reset();
      push(2, 1);
      step();
      req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (grant != '0) break;
         step();
      end
      check("pre_rst_grant_seen", int'(grant != '0), 1);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("grant_in_rst", int'(grant), 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_write_enable", int'(fifo_write_enable), 0);
      check("post_rst_occupancy", int'(occupancy), 0);
      push(0, 1);
      run_req(4'b1111, 1, cyc);

`ifdef FIFO_WR_ARBITER_STATS_EN
      do_reset();
      auto_rd = 1'b1;
      push(2, 10);
      run_req(4'b0100, 10, cyc);
      repeat (3) step();
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         check("grant_cnt", int'(grant_cnt[i*16 +: 16]), (i == 2) ? 10 : 0);
      end
      auto_rd = 1'b0;
      fifo_read_enable = 1'b0;
`endif

      repeat (5) step();
      check("grants_left", exp_g.size(), 0);
      check("writes_left", exp_d.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
